// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction memory block.
package imem_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;
  localparam logic [31:0] DEFAULT_NOP   = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH x 32, one synchronous write port, one synchronous read port.
module imem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Index may be wider than needed; callers only enable accesses below DEPTH.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata_q <= mem[raddr[IW-1:0]];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_prog.sv
// Programmable instruction memory: LOAD/RUN state machine, load handshake and fetch port.
module imem_prog
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [31:0]   a,
  input  logic          stall,
  input  logic          flush,
  output logic [31:0]   rd,
  output logic          rd_valid,
  output logic          misalign,
  output logic          oob,
  input  logic          prog_valid,
  output logic          prog_ready,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          prog_last,
  input  logic          reload,
  output logic          loading,
  output logic          prog_err
);

  state_e      state_q, state_d;
  logic        rd_valid_q, rd_valid_d;
  logic        misalign_q, misalign_d;
  logic        oob_q, oob_d;
  logic        prog_err_q, prog_err_d;
  logic        beat_acc, beat_in_range, f_mis, f_oob, fetch_fire;
  logic        ram_we, ram_re;
  logic [31:0] ram_rdata;

  always_comb begin
    beat_acc      = prog_valid && (state_q == ST_LOAD);
    beat_in_range = 32'(prog_addr) < DEPTH;
    ram_we        = beat_acc && beat_in_range && !rst;
    f_mis         = a[1:0] != 2'b00;
    f_oob         = {2'b00, a[31:2]} >= DEPTH;
    fetch_fire    = (state_q == ST_RUN) && !reload && !flush && !stall && req_valid;
    ram_re        = fetch_fire && !f_mis && !f_oob;

    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    misalign_d = misalign_q;
    oob_d      = oob_q;
    prog_err_d = prog_err_q;

    case (state_q)
      ST_LOAD: begin
        rd_valid_d = 1'b0;
        misalign_d = 1'b0;
        oob_d      = 1'b0;
        if (beat_acc) begin
          if (!beat_in_range) prog_err_d = 1'b1;
          if (prog_last)      state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_d    = ST_LOAD;
          prog_err_d = 1'b0;
          rd_valid_d = 1'b0;
          misalign_d = 1'b0;
          oob_d      = 1'b0;
        end else if (flush) begin
          rd_valid_d = 1'b0;
          misalign_d = 1'b0;
          oob_d      = 1'b0;
        end else if (!stall) begin
          rd_valid_d = req_valid && !f_mis && !f_oob;
          misalign_d = req_valid && f_mis;
          oob_d      = req_valid && f_oob;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      oob_q      <= 1'b0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      misalign_q <= misalign_d;
      oob_q      <= oob_d;
      prog_err_q <= prog_err_d;
    end
  end

  imem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .re   (ram_re),
    .raddr(a[AW+1:2]),
    .rdata(ram_rdata)
  );

  // The RAM read register holds during stall, so rd only needs a NOP select
  // driven by the registered valid bit.
  assign rd         = rd_valid_q ? ram_rdata : NOP_INSTR;
  assign rd_valid   = rd_valid_q;
  assign misalign   = misalign_q;
  assign oob        = oob_q;
  assign prog_err   = prog_err_q;
  assign prog_ready = (state_q == ST_LOAD);
  assign loading    = (state_q == ST_LOAD);

endmodule

// File: doc/imem_prog.md
IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words.
REQ-002 Parameter AW, default $clog2(DEPTH), width of the word index.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, instruction returned on any non-valid fetch.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  fetch request this cycle.
REQ-007 a  in  32  fetch byte address.
REQ-008 stall  in  1  hold fetch outputs (pipeline stall).
REQ-009 flush  in  1  kill the fetch in flight (branch/jump taken).
REQ-010 rd  out  32  fetched instruction, registered.
REQ-011 rd_valid  out  1  rd holds a real instruction.
REQ-012 misalign  out  1  registered; the fetch had a[1:0] != 0.
REQ-013 oob  out  1  registered; the fetch had a[31:2] >= DEPTH.
REQ-014 prog_valid / prog_ready  in / out  1 / 1  program-load handshake.
REQ-015 prog_addr  in  AW  word index of the load beat.
REQ-016 prog_data  in  32  instruction word of the load beat.
REQ-017 prog_last  in  1  final beat of the load.
REQ-018 reload  in  1  in RUN, return to LOAD.
REQ-019 loading  out  1  high in LOAD state.
REQ-020 prog_err  out  1  sticky; a beat was dropped because prog_addr >= DEPTH.

Function
REQ-021 The state machine SHALL have two states: LOAD and RUN.
REQ-022 LOAD SHALL assert prog_ready=1 and loading=1; RUN SHALL assert prog_ready=0 and loading=0.
REQ-023 A beat SHALL be accepted when prog_valid && prog_ready, writing prog_data to RAM[prog_addr] at that edge.
REQ-024 An accepted beat with prog_addr >= DEPTH SHALL NOT write, and SHALL set prog_err.
REQ-025 An accepted beat with prog_last=1 SHALL move the block LOAD->RUN at the same edge.
REQ-026 reload=1 in RUN SHALL move the block RUN->LOAD at the next edge, clear prog_err, and force rd_valid=0 and rd=NOP_INSTR.
REQ-027 In RUN, a fetch with req_valid=1, stall=0 and flush=0 SHALL present RAM[a[AW+1:2]] on rd with rd_valid=1 exactly one cycle later.
REQ-028 A misaligned or out-of-range fetch SHALL give rd=NOP_INSTR, rd_valid=0 and the matching flag=1 one cycle later; both flags may assert together.
REQ-029 req_valid=0 with stall=0 SHALL give rd=NOP_INSTR, rd_valid=0 and both flags=0 next cycle.
REQ-030 stall=1 SHALL hold rd, rd_valid, misalign and oob unchanged.
REQ-031 flush=1 SHALL have priority over stall and req_valid, giving rd=NOP_INSTR with rd_valid, misalign and oob all 0 next cycle.
REQ-032 In LOAD, fetch outputs SHALL be rd=NOP_INSTR with rd_valid, misalign and oob all 0, regardless of fetch inputs.
REQ-033 Address bits above AW+1 SHALL be used only for the oob check.

Reset
REQ-034 rst SHALL immediately force state=LOAD, rd=NOP_INSTR, rd_valid=0, misalign=0, oob=0 and prog_err=0.
REQ-035 RAM contents SHALL NOT be reset.
REQ-036 A beat presented during reset SHALL NOT be written.
REQ-037 Reset asserted mid-load SHALL discard load progress; the words already written SHALL remain in RAM.

Structure
REQ-038 NOP_INSTR default, the state encoding (LOAD=0, RUN=1) and default DEPTH SHALL reside in the shared package imem_pkg.
REQ-039 Storage SHALL be the sub-module imem_ram: DEPTH x 32, one synchronous write port, one synchronous read port, no reset.
REQ-040 imem_prog SHALL contain the FSM, the handshake and the output registers.

Verification
REQ-041 Load 0x7FF00F13@0, 0x01EF0F33@1, last=1 at beat 1 -> prog_ready falls after the last beat; fetch a=0x4 -> rd=0x01EF0F33, rd_valid=1 one cycle later.
REQ-042 In RUN, fetch a=0x6 -> misalign=1, rd=0x00000013, rd_valid=0; fetch a=DEPTH*4 -> oob=1.
REQ-043 Fetch a=0x0 with stall=1 for 3 cycles -> rd=0x7FF00F13 is held for all 3 cycles; stall=1 with flush=1 -> rd=NOP, rd_valid=0 next cycle.
REQ-044 Load beat with prog_addr=DEPTH (AW widened in the bench) -> prog_err=1 and no RAM write; reload -> prog_err=0 and loading=1.
REQ-045 Reset asserted between beats 1 and 2 of a 4-beat load -> outputs take reset values immediately; a new full load then completes and fetches return the new data.
